// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, ALU/immediate encodings and
// the forwarding-mux select values used by the hazard unit.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // The younger (MEM) producer always wins over the older (WB) one.
  function automatic fwd_sel_t fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit) begin
      return FWD_MEM;
    end else if (wb_hit) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_pipe_reg.sv
// One pipeline stage's control register: reset and bubble-insertion clear
// both load zeros, otherwise the stage simply captures its input.
module ctrl_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset and clear are both synchronous; clear turns the stage into a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Control-side pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// taken-branch flush, operand forwarding select and saturating event counters.
module hazard_pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_alu_src,
  input  logic              id_mem_write,
  input  logic              id_result_src,
  input  logic              id_branch,
  input  logic [2:0]        id_alu_control,
  input  logic              ex_zero,
  output logic              ex_reg_write,
  output logic              ex_alu_src,
  output logic              ex_mem_write,
  output logic              ex_result_src,
  output logic              ex_branch,
  output logic [2:0]        ex_alu_control,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_write,
  output logic              mem_result_src,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_reg_write,
  output logic              wb_result_src,
  output logic [REG_AW-1:0] wb_rd,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              pc_src_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int IDEX_W  = 8 + 3 * REG_AW;
  localparam int EXMEM_W = 3 + REG_AW;
  localparam int MEMWB_W = 2 + REG_AW;

  logic               lu;
  logic               idex_clear;
  logic [IDEX_W-1:0]  idex_d;
  logic [IDEX_W-1:0]  idex_q;
  logic [EXMEM_W-1:0] exmem_d;
  logic [EXMEM_W-1:0] exmem_q;
  logic [MEMWB_W-1:0] memwb_d;
  logic [MEMWB_W-1:0] memwb_q;

  assign idex_d = {id_reg_write, id_alu_src, id_mem_write, id_result_src, id_branch,
                   id_alu_control, id_rs1, id_rs2, id_rd};
  assign idex_clear = flush_e | ~id_valid;

  ctrl_pipe_reg #(.W(IDEX_W)) u_id_ex (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (idex_clear),
    .d     (idex_d),
    .q     (idex_q)
  );

  assign {ex_reg_write, ex_alu_src, ex_mem_write, ex_result_src, ex_branch,
          ex_alu_control, ex_rs1, ex_rs2, ex_rd} = idex_q;

  assign exmem_d = {ex_reg_write, ex_mem_write, ex_result_src, ex_rd};

  ctrl_pipe_reg #(.W(EXMEM_W)) u_ex_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .d     (exmem_d),
    .q     (exmem_q)
  );

  assign {mem_reg_write, mem_mem_write, mem_result_src, mem_rd} = exmem_q;

  assign memwb_d = {mem_reg_write, mem_result_src, mem_rd};

  ctrl_pipe_reg #(.W(MEMWB_W)) u_mem_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .d     (memwb_d),
    .q     (memwb_q)
  );

  assign {wb_reg_write, wb_result_src, wb_rd} = memwb_q;

  // Load-use stall and branch flush; a taken branch discards the stalled instruction anyway.
  always_comb begin
    pc_src_e = ex_branch & ex_zero;
    lu       = id_valid & ex_result_src & ex_reg_write & (ex_rd != '0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    stall_f  = lu & ~pc_src_e;
    stall_d  = lu & ~pc_src_e;
    flush_d  = pc_src_e;
    flush_e  = lu | pc_src_e;
  end

  // Operand forwarding select; writes to x0 are never forwarded.
  always_comb begin
    fwd_a_e = fwd_select(mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1),
                         wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs1));
    fwd_b_e = fwd_select(mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2),
                         wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs2));
  end

  // Stall and flush event counters that stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_d && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
